// File: rtl/radix2_div_axis_pkg.sv
// radix2_div_axis_pkg: shared FSM states, counter sizing and result field order for the radix-2 divider
package radix2_div_axis_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int W_DEF = 32;
  localparam int CNT_W = $clog2(W_DEF) + 1;
  // result halves: quotient in the upper W bits, remainder in the lower W bits
  localparam int QUO_FIELD = 1;
  localparam int REM_FIELD = 0;
  function automatic int cnt_w(int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/radix2_div_axis_if.sv
// radix2_div_axis_if: split-operand divide handshake; dividend/divisor valid-ready-data channels in, one-cycle quotient/remainder pulse out
interface radix2_div_axis_if #(parameter int W = 32);
  logic s_axis_dividend_tvalid;
  logic s_axis_dividend_tready;
  logic [W-1:0] s_axis_dividend_tdata;
  logic s_axis_divisor_tvalid;
  logic s_axis_divisor_tready;
  logic [W-1:0] s_axis_divisor_tdata;
  logic m_axis_dout_tvalid;
  logic [2*W-1:0] m_axis_dout_tdata;
  modport slave (
    input s_axis_dividend_tvalid, s_axis_dividend_tdata, s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tvalid, m_axis_dout_tdata
  );
  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata, s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/radix2_div_axis_step.sv
// div_restoring_step: one restoring radix-2 iteration; rem/quo/dvs in, rem_nx/quo_nx out
module div_restoring_step import radix2_div_axis_pkg::*; #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nx,
  output logic [W-1:0] quo_nx
);
  logic [W-1:0] r_sh, q_sh;
  logic [W:0] t;
  always_comb begin
    {r_sh, q_sh} = {rem, quo} << 1;
    t = {1'b0, r_sh} - {1'b0, dvs};
    rem_nx = t[W] ? r_sh : t[W-1:0];
    quo_nx = t[W] ? q_sh : {q_sh[W-1:1], 1'b1};
  end
endmodule

// File: rtl/radix2_div_axis.sv
// radix2_div_axis: multi-cycle restoring divider; clk, reset (sync, active-high), io = split operand channels in, {quotient, remainder} pulse out
module radix2_div_axis import radix2_div_axis_pkg::*; #(
  parameter int W = 32,
  parameter bit SIGNED = 1
) (
  input logic clk,
  input logic reset,
  radix2_div_axis_if.slave io
);
  localparam int CW = cnt_w(W);
  state_t state, state_nx;
  logic have_dd, have_dv, dd_fire, dv_fire, load, last, sd, sv, sign_q, sign_r;
  logic [W-1:0] dd, dv, dd_op, dv_op, rem, quo, dvs, rem_nx, quo_nx;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] dout;
  div_restoring_step #(.W(W)) u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_nx(rem_nx), .quo_nx(quo_nx));
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (load ? BUSY : IDLE) : (state == BUSY) ? (last ? DONE : BUSY) : IDLE;
  always_comb begin
    io.s_axis_dividend_tready = (state == IDLE) && !have_dd;
    io.s_axis_divisor_tready = (state == IDLE) && !have_dv;
    io.m_axis_dout_tvalid = state == DONE;
    io.m_axis_dout_tdata = dout;
    dd_fire = io.s_axis_dividend_tvalid && io.s_axis_dividend_tready;
    dv_fire = io.s_axis_divisor_tvalid && io.s_axis_divisor_tready;
    load = (state == IDLE) && (have_dd || dd_fire) && (have_dv || dv_fire);
    last = (state == BUSY) && (cnt == CW'(W - 1));
  end
  // an operand arriving on the load edge is used straight from the bus
  assign dd_op = have_dd ? dd : io.s_axis_dividend_tdata;
  assign dv_op = have_dv ? dv : io.s_axis_divisor_tdata;
  assign sd = SIGNED && dd_op[W-1];
  assign sv = SIGNED && dv_op[W-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      have_dd <= 1'b0;
      have_dv <= 1'b0;
      cnt <= '0;
      dout <= '0;
    end else begin
      if (load) begin
        have_dd <= 1'b0;
        have_dv <= 1'b0;
        rem <= '0;
        quo <= sd ? -dd_op : dd_op;
        dvs <= sv ? -dv_op : dv_op;
        cnt <= '0;
        sign_q <= sd ^ sv;
        sign_r <= sd;
      end else begin
        if (dd_fire) begin
          dd <= io.s_axis_dividend_tdata;
          have_dd <= 1'b1;
        end
        if (dv_fire) begin
          dv <= io.s_axis_divisor_tdata;
          have_dv <= 1'b1;
        end
      end
      if (state == BUSY) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        dout[QUO_FIELD*W +: W] <= sign_q ? -quo_nx : quo_nx;
        dout[REM_FIELD*W +: W] <= sign_r ? -rem_nx : rem_nx;
      end
    end
  end
endmodule

// File: tb/tb_radix2_div_axis.sv
// tb_radix2_div_axis: scoreboard bench for signed and unsigned divider copies
module tb_radix2_div_axis;
  localparam int W = 32;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  radix2_div_axis_if #(.W(W)) if_s ();
  radix2_div_axis_if #(.W(W)) if_u ();
  radix2_div_axis #(.W(W), .SIGNED(1)) dut_s (.clk(clk), .reset(reset), .io(if_s));
  radix2_div_axis #(.W(W), .SIGNED(0)) dut_u (.clk(clk), .reset(reset), .io(if_u));
  logic dd_valid [2], dv_valid [2], dd_ready [2], dv_ready [2], dout_valid [2];
  logic [W-1:0] dd_data [2], dv_data [2];
  logic [2*W-1:0] dout_data [2];
  assign if_s.s_axis_dividend_tvalid = dd_valid[0];
  assign if_s.s_axis_dividend_tdata = dd_data[0];
  assign if_s.s_axis_divisor_tvalid = dv_valid[0];
  assign if_s.s_axis_divisor_tdata = dv_data[0];
  assign if_u.s_axis_dividend_tvalid = dd_valid[1];
  assign if_u.s_axis_dividend_tdata = dd_data[1];
  assign if_u.s_axis_divisor_tvalid = dv_valid[1];
  assign if_u.s_axis_divisor_tdata = dv_data[1];
  assign dd_ready[0] = if_s.s_axis_dividend_tready;
  assign dv_ready[0] = if_s.s_axis_divisor_tready;
  assign dout_valid[0] = if_s.m_axis_dout_tvalid;
  assign dout_data[0] = if_s.m_axis_dout_tdata;
  assign dd_ready[1] = if_u.s_axis_dividend_tready;
  assign dv_ready[1] = if_u.s_axis_divisor_tready;
  assign dout_valid[1] = if_u.m_axis_dout_tvalid;
  assign dout_data[1] = if_u.m_axis_dout_tdata;
  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction
  // C-style truncating division; divide by zero yields all-ones magnitude with the dividend as remainder
  function automatic logic [63:0] ref_div(bit sgn, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (sb == 0) begin
      q = (sgn && sa < 0) ? 64'sd1 : -64'sd1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {q[31:0], r[31:0]};
  endfunction
  // transaction-level model: held operands, cycles left until the unit is free, expected results
  bit held_dd [2], held_dv [2];
  int busy_left [2] = '{0, 0};
  int prev_pulse [2], last_pulse [2];
  logic [W-1:0] a_m [2], b_m [2];
  logic [63:0] sbq [2][$];
  logic [64:0] dir_q [2][$];
  logic erd, erv;
  logic [63:0] e;
  logic [64:0] h;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        held_dd[i] = 0;
        held_dv[i] = 0;
        busy_left[i] = 0;
        sbq[i].delete();
        dir_q[i].delete();
      end else begin
        erd = busy_left[i] == 0 && !held_dd[i];
        erv = busy_left[i] == 0 && !held_dv[i];
        chk($sformatf("dividend_tready[%0d]", i), 64'(dd_ready[i]), 64'(erd));
        chk($sformatf("divisor_tready[%0d]", i), 64'(dv_ready[i]), 64'(erv));
        chk($sformatf("dout_tvalid[%0d]", i), 64'(dout_valid[i]), 64'(busy_left[i] == 1));
        if (dout_valid[i]) begin
          prev_pulse[i] = last_pulse[i];
          last_pulse[i] = cyc;
          if (sbq[i].size() == 0) chk($sformatf("unexpected_pulse[%0d]", i), 64'(1), 64'(0));
          else begin
            e = sbq[i].pop_front();
            chk($sformatf("dout_tdata[%0d]", i), dout_data[i], e);
          end
          if (dir_q[i].size() != 0) begin
            h = dir_q[i].pop_front();
            if (h[64]) chk($sformatf("directed_result[%0d]", i), dout_data[i], h[63:0]);
          end
        end
        if (busy_left[i] > 0) busy_left[i]--;
        else begin
          if (dd_valid[i] && erd) begin held_dd[i] = 1; a_m[i] = dd_data[i]; end
          if (dv_valid[i] && erv) begin held_dv[i] = 1; b_m[i] = dv_data[i]; end
          if (held_dd[i] && held_dv[i]) begin
            sbq[i].push_back(ref_div(i == 0, a_m[i], b_m[i]));
            held_dd[i] = 0;
            held_dv[i] = 0;
            busy_left[i] = W + 1;
          end
        end
      end
    end
  end
  task automatic op(int i, logic [W-1:0] a, logic [W-1:0] b, int ga, int gb, bit hint, logic [63:0] exp, bit glitch);
    bit da = 0, db = 0, fa, fb;
    if (glitch) begin
      @(negedge clk);
      if (!dd_ready[i]) begin
        dd_valid[i] = 1;
        dd_data[i] = $urandom;
        @(posedge clk); #1;
        dd_valid[i] = 0;
      end
    end
    for (int k = 0; k < 400 && !(da && db); k++) begin
      if (k == ga) begin dd_valid[i] = 1; dd_data[i] = a; end
      if (k == gb) begin dv_valid[i] = 1; dv_data[i] = b; end
      @(negedge clk);
      fa = dd_valid[i] && dd_ready[i];
      fb = dv_valid[i] && dv_ready[i];
      @(posedge clk); #1;
      if (fa) begin dd_valid[i] = 0; da = 1; end
      if (fb) begin dv_valid[i] = 0; db = 1; end
    end
    chk($sformatf("op_accepted[%0d]", i), {62'b0, da, db}, 64'd3);
    if (da && db) dir_q[i].push_back({hint, exp});
  endtask
  task automatic wait_idle(int i);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = busy_left[i] == 0 && !held_dd[i] && !held_dv[i];
    end
    chk($sformatf("idle_reached[%0d]", i), 64'(ok), 64'(1));
    @(posedge clk); #1;
  endtask
  task automatic rand_ops(int i, int n);
    logic [W-1:0] a, b;
    int sel;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 5);
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? $urandom_range(1, 15) : $urandom;
      op(i, a, b, $urandom_range(0, 3), $urandom_range(0, 3), 0, 64'h0, $urandom_range(0, 1) == 1);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin
      dd_valid[i] = 0; dv_valid[i] = 0; dd_data[i] = '0; dv_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_tvalid[%0d]", i), 64'(dout_valid[i]), 64'(0));
      chk($sformatf("reset_tdata[%0d]", i), dout_data[i], 64'h0);
    end
    @(posedge clk); #1;
    op(0, 32'd7, 32'hFFFF_FFFE, 0, 0, 1, 64'hFFFF_FFFD_0000_0001, 0);
    op(0, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 64'hFFFF_FFFD_FFFF_FFFF, 0);
    op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 64'h8000_0000_0000_0000, 0);
    wait_idle(0);
    op(0, 32'd123, 32'd10, 0, 3, 1, {32'd12, 32'd3}, 0);
    wait_idle(0);
    op(0, 32'd1000, 32'd3, 0, 0, 1, {32'd333, 32'd1}, 0);
    op(0, 32'hFFFF_FC18, 32'd3, 0, 0, 1, 64'hFFFF_FEB3_FFFF_FFFF, 0);
    wait_idle(0);
    chk("back_to_back_gap", 64'(last_pulse[0] - prev_pulse[0]), 64'(W + 2));
    op(0, 32'd5000, 32'd3, 0, 0, 0, 64'h0, 0);
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("post_reset_dividend_tready", 64'(dd_ready[0]), 64'(1));
    chk("post_reset_divisor_tready", 64'(dv_ready[0]), 64'(1));
    @(posedge clk); #1;
    op(0, 32'd100, 32'd7, 0, 0, 1, {32'd14, 32'd2}, 0);
    rand_ops(0, 20);
    wait_idle(0);
    op(1, 32'hFFFF_FFFF, 32'h10, 0, 0, 1, 64'h0FFF_FFFF_0000_000F, 0);
    op(1, 32'd100, 32'd0, 0, 0, 1, {32'hFFFF_FFFF, 32'd100}, 0);
    rand_ops(1, 20);
    wait_idle(1);
    for (int i = 0; i < 2; i++) chk($sformatf("scoreboard_drained[%0d]", i), 64'(sbq[i].size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
